// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: packs little-endian bytes into 32-bit words,
// writes them to an instruction memory and holds the CPU until the load completes.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_waddr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             cpu_hold,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_W = CNT_W'(DEPTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      word_q, word_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;

    logic [CNT_W-1:0] start_count;
    logic [CNT_W-1:0] idx_next;

    // Requests larger than the memory are clipped so the address never leaves the array.
    assign start_count = (num_words > DEPTH_W) ? DEPTH_W : num_words;
    assign idx_next    = word_idx_q + CNT_W'(1);

    always_comb begin
        // NOTE: every *_d gets its hold value first, so no path through the case leaves one unassigned (no latches).
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d    = start_count;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    word_d     = '0;
                    state_d    = (start_count == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (byte_valid) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Write port registers are loaded here so they are stable for the whole WRITE cycle.
                        waddr_d = 32'(word_idx_q) << 2;
                        wdata_d = {byte_data, word_q[23:0]};
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = idx_next;
                state_d    = (idx_next == count_q) ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    // All control outputs come straight from the registered state, so they are glitch-free.
    always_comb begin
        byte_ready = (state_q == S_COLLECT);
        mem_we     = (state_q == S_WRITE);
        busy       = (state_q != S_IDLE);
        cpu_hold   = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
    end

    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;

    a_waddr_legal: assert property (@(posedge clk) disable iff (!reset_n)
        mem_we |-> (mem_waddr[1:0] == 2'b00 && mem_waddr <= 32'((DEPTH - 1) * 4)));

    a_we_single: assert property (@(posedge clk) disable iff (!reset_n)
        mem_we |=> !mem_we);

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64, is the number of 32-bit words in the target instruction memory.
REQ-002 Parameter CNT_W, default 7, is the width of num_words and the internal word counter.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 num_words  input  CNT_W  number of words to load, sampled when start is accepted.
REQ-007 byte_valid  input  1  byte_data carries a valid byte.
REQ-008 byte_data  input  8  program byte stream, little-endian within each word.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  write strobe to the instruction-memory write port.
REQ-011 mem_waddr  output  32  byte address of the write, word-aligned, in the same format as the fetch read_address.
REQ-012 mem_wdata  output  32  assembled instruction word.
REQ-013 busy  output  1  load in progress.
REQ-014 cpu_hold  output  1  holds the processor in reset or stall while high.
REQ-015 done  output  1  one-cycle pulse at load completion.

Function
REQ-016 The loader SHALL implement the states IDLE, COLLECT, WRITE and DONE, and SHALL decode all control outputs from registered state only.
REQ-017 In IDLE, start=1 SHALL latch count = min(num_words, DEPTH), clear word_idx and byte_cnt, and go to COLLECT, or go straight to DONE if count=0.
REQ-018 In COLLECT, byte_ready SHALL be 1, and a byte is accepted only on a cycle with byte_valid && byte_ready.
REQ-019 Accepted byte k (0..3) SHALL be written to word bits [8k+7:8k], and byte_cnt SHALL wrap from 3 to 0.
REQ-020 Acceptance of the 4th byte SHALL move the FSM to WRITE on the next edge.
REQ-021 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_waddr = word_idx<<2 and mem_wdata = the assembled word, and byte_ready SHALL be 0.
REQ-022 After WRITE, word_idx SHALL increment, then the FSM SHALL go to DONE if word_idx+1 == count and to COLLECT otherwise.
REQ-023 In DONE, done SHALL be 1 for one cycle, and the FSM SHALL then return to IDLE.
REQ-024 Latency: 4th byte accepted in cycle N -> mem_we in cycle N+1 -> next byte acceptable no earlier than cycle N+2, giving 5 cycles per word at full rate.
REQ-025 busy and cpu_hold SHALL be 1 in every state except IDLE.
REQ-026 byte_ready SHALL be 1 only in COLLECT, and bytes presented in other states SHALL be ignored (not consumed).
REQ-027 A start asserted while busy=1 SHALL be ignored, with count and progress unchanged.
REQ-028 Gaps in byte_valid SHALL only stall the FSM and SHALL never cause a write or corrupt partial data.
REQ-029 mem_waddr SHALL never exceed (DEPTH-1)<<2, and mem_waddr[1:0] SHALL always be 0.
REQ-030 Outside WRITE, mem_wdata and mem_waddr SHALL hold their last values, and mem_we SHALL be 0.

Reset
REQ-031 reset_n=0 SHALL immediately (asynchronously) force IDLE and clear word_idx, byte_cnt, count, the assembled word, mem_waddr and mem_wdata to 0.
REQ-032 During reset, all 1-bit outputs (byte_ready, mem_we, busy, cpu_hold, done) SHALL be 0.
REQ-033 Reset asserted mid-load SHALL discard the partial word and SHALL issue no further writes; words already written remain in memory.
REQ-034 After reset_n deasserts, the block SHALL need a new start before any activity.

Verification
REQ-035 Reset: hold reset_n=0 with start=1 and byte_valid=1 -> all outputs 0, and no mem_we for the whole reset period.
REQ-036 Basic load: num_words=2, stream 13 04 50 00 93 04 30 00 with byte_valid=1 continuously -> mem_we with addr 0x0 / data 0x00500413, then addr 0x4 / data 0x00300493, then done for one cycle, then busy=0.
REQ-037 Stalls: same stream with byte_valid deasserted for 3 cycles between every byte -> identical writes, exactly 2 mem_we pulses, byte_ready=0 during WRITE.
REQ-038 Boundaries: num_words=0 -> done one cycle after start with no mem_we; num_words=100 -> exactly 64 writes, the last at addr 0xFC.
REQ-039 Abort: reset_n pulsed low after 2 bytes of word 0 -> busy=0 at once and no mem_we; a following load of 1 word 0xFFFFF113 writes addr 0x0 correctly.
REQ-040 Start while busy: start pulsed during the second word of a 3-word load -> exactly 3 writes at addr 0x0, 0x4 and 0x8, and a single done pulse.
